riscv_alu_mc: RTL

Parametrised multi-cycle RISC-V integer ALU. It executes the full RV32I register-register operation set in one registered cycle, plus unsigned multiply (low and high word) on an iterative shift-add datapath taking BUS_WIDTH cycles. It sits in the EX stage and talks to issue logic through a valid/ready handshake. A kill input allows a pipeline flush to abort an in-flight multiply.

---
 rtl/riscv_alu_mc.sv | 129 ++++++++++++
 1 files changed

// File: rtl/riscv_alu_mc.sv
// Multi-cycle RV32I register-register ALU. Single-cycle ops finish one cycle
// after they are accepted. MUL/MULHU run on an iterative shift-add datapath
// for BUS_WIDTH steps. i_Kill aborts the current operation.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | ready; single-cycle ops complete here without leaving
//   S_MUL  | shift-add multiply in progress; requests are ignored
module riscv_alu_mc #(
  parameter int BUS_WIDTH  = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_Valid,
  input  logic                  i_Kill,
  input  logic [CTRL_WIDTH-1:0] i_Control,
  input  logic [BUS_WIDTH-1:0]  i_OP1,
  input  logic [BUS_WIDTH-1:0]  i_OP2,
  output logic                  o_Ready,
  output logic                  o_Valid,
  output logic [BUS_WIDTH-1:0]  o_Result,
  output logic                  o_Zero
);

  localparam int SH = $clog2(BUS_WIDTH);
  localparam logic [SH-1:0] LAST_STEP = SH'(BUS_WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t                 state, state_nxt;
  logic [SH-1:0]          step_cnt;
  logic [2*BUS_WIDTH-1:0] acc, acc_nxt;
  logic [BUS_WIDTH-1:0]   mcand, mplier;
  logic                   mul_hi;
  logic                   accept, is_mul, mul_last;
  logic [SH-1:0]          shamt;
  logic [BUS_WIDTH-1:0]   alu_res, mul_res, addend;
  logic [BUS_WIDTH:0]     upper_sum;

  assign shamt    = i_OP2[SH-1:0];
  assign is_mul   = (i_Control == 4'b1001) || (i_Control == 4'b1010);
  assign accept   = i_Valid && (state == S_IDLE) && !i_Kill;
  assign mul_last = (state == S_MUL) && (step_cnt == LAST_STEP);
  assign o_Ready  = (state == S_IDLE);

  // Single-cycle result; unlisted codes give zero.
  always_comb begin
    alu_res = '0;
    case (i_Control)
      4'b0000: alu_res = i_OP1 + i_OP2;
      4'b0001: alu_res = i_OP1 << shamt;
      4'b0010: alu_res = {{(BUS_WIDTH-1){1'b0}}, $signed(i_OP1) < $signed(i_OP2)};
      4'b0011: alu_res = {{(BUS_WIDTH-1){1'b0}}, i_OP1 < i_OP2};
      4'b0100: alu_res = i_OP1 ^ i_OP2;
      4'b0101: alu_res = i_OP1 >> shamt;
      4'b0110: alu_res = i_OP1 | i_OP2;
      4'b0111: alu_res = i_OP1 & i_OP2;
      4'b1000: alu_res = i_OP1 - i_OP2;
      4'b1101: alu_res = BUS_WIDTH'($signed(i_OP1) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add multiplicand into the upper half (keeping the
  // carry), then shift the whole accumulator right by one.
  always_comb begin
    addend    = mplier[0] ? mcand : '0;
    upper_sum = {1'b0, acc[2*BUS_WIDTH-1:BUS_WIDTH]} + {1'b0, addend};
    acc_nxt   = {upper_sum, acc[BUS_WIDTH-1:1]};
    mul_res   = mul_hi ? acc_nxt[2*BUS_WIDTH-1:BUS_WIDTH] : acc_nxt[BUS_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; kill overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_mul) state_nxt = S_MUL;
      S_MUL:   if (mul_last)         state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (i_Kill) state_nxt = S_IDLE;
  end

  // Datapath and result registers; a killed operation leaves outputs untouched.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      step_cnt <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      mul_hi   <= 1'b0;
      o_Valid  <= 1'b0;
      o_Result <= '0;
      o_Zero   <= 1'b1;
    end else begin
      o_Valid <= 1'b0;
      if (accept) begin
        if (is_mul) begin
          mcand    <= i_OP1;
          mplier   <= i_OP2;
          mul_hi   <= (i_Control == 4'b1010);
          acc      <= '0;
          step_cnt <= '0;
        end else begin
          o_Result <= alu_res;
          o_Zero   <= (alu_res == '0);
          o_Valid  <= 1'b1;
        end
      end else if (state == S_MUL && !i_Kill) begin
        acc      <= acc_nxt;
        mplier   <= mplier >> 1;
        step_cnt <= step_cnt + SH'(1);
        if (mul_last) begin
          o_Result <= mul_res;
          o_Zero   <= (mul_res == '0);
          o_Valid  <= 1'b1;
        end
      end
    end
  end

endmodule
